// File: rtl/aes_encipher_block_if.sv
// Signal bundle between the AES encipher datapath, its key memory, the shared S-box
// and the block-level controller.
interface aes_encipher_block_if;
    logic         next;
    logic         keylen;
    logic [3:0]   round;
    logic [127:0] round_key;
    logic [31:0]  sboxw;
    logic [31:0]  new_sboxw;
    logic [127:0] block;
    logic [127:0] new_block;
    logic         ready;

    modport master (
        output next, keylen, round_key, new_sboxw, block,
        input  round, sboxw, new_block, ready
    );

    modport slave (
        input  next, keylen, round_key, new_sboxw, block,
        output round, sboxw, new_block, ready
    );
endinterface

// File: rtl/aes_encipher_block.sv
// Iterative AES-128/256 encryption: one round per 5 cycles, SubBytes one word per
// cycle through an external S-box, round keys read combinationally by round index.
module aes_encipher_block (
    input logic                 clk,
    input logic                 reset_n,
    aes_encipher_block_if.slave bus
);

    localparam logic [3:0] AES_128_NUM_ROUNDS = 4'd10;
    localparam logic [3:0] AES_256_NUM_ROUNDS = 4'd14;

    typedef enum logic [1:0] {StIdle, StInit, StSbox, StMain} state_e;

    state_e       state_q, state_d;
    logic [127:0] block_q, block_d;
    logic [3:0]   round_ctr_q, round_ctr_d;
    logic [1:0]   word_ctr_q, word_ctr_d;
    logic         keylen_q, keylen_d;
    logic         ready_q, ready_d;
    logic [31:0]  sboxw;
    logic [3:0]   num_rounds;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (8'h1b & {8{b[7]}});
    endfunction

    function automatic logic [31:0] mix_word(input logic [31:0] w);
        logic [7:0] b0, b1, b2, b3;
        logic [7:0] r0, r1, r2, r3;
        b0 = w[31:24];
        b1 = w[23:16];
        b2 = w[15:8];
        b3 = w[7:0];
        r0 = xtime(b0) ^ xtime(b1) ^ b1 ^ b2 ^ b3;
        r1 = b0 ^ xtime(b1) ^ xtime(b2) ^ b2 ^ b3;
        r2 = b0 ^ b1 ^ xtime(b2) ^ xtime(b3) ^ b3;
        r3 = xtime(b0) ^ b0 ^ b1 ^ b2 ^ xtime(b3);
        return {r0, r1, r2, r3};
    endfunction

    // Column-major state: byte (row r, col c) sits at bit offset 127 - 8*(4c + r).
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8 * (4 * c + r) -: 8] = s[127 - 8 * (4 * ((c + r) % 4) + r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        return {mix_word(s[127:96]), mix_word(s[95:64]), mix_word(s[63:32]),
                mix_word(s[31:0])};
    endfunction

    assign num_rounds = keylen_q ? AES_256_NUM_ROUNDS : AES_128_NUM_ROUNDS;

    always_comb begin
        state_d     = state_q;
        block_d     = block_q;
        round_ctr_d = round_ctr_q;
        word_ctr_d  = word_ctr_q;
        keylen_d    = keylen_q;
        ready_d     = ready_q;
        sboxw       = '0;

        unique case (state_q)
            StIdle: begin
                if (bus.next) begin
                    keylen_d    = bus.keylen;
                    ready_d     = 1'b0;
                    round_ctr_d = 4'd0;
                    state_d     = StInit;
                end
            end

            StInit: begin
                block_d     = bus.block ^ bus.round_key;
                round_ctr_d = 4'd1;
                word_ctr_d  = 2'd0;
                state_d     = StSbox;
            end

            StSbox: begin
                unique case (word_ctr_q)
                    2'd0: begin
                        sboxw           = block_q[127:96];
                        block_d[127:96] = bus.new_sboxw;
                    end
                    2'd1: begin
                        sboxw          = block_q[95:64];
                        block_d[95:64] = bus.new_sboxw;
                    end
                    2'd2: begin
                        sboxw          = block_q[63:32];
                        block_d[63:32] = bus.new_sboxw;
                    end
                    default: begin
                        sboxw         = block_q[31:0];
                        block_d[31:0] = bus.new_sboxw;
                    end
                endcase
                word_ctr_d = word_ctr_q + 2'd1;
                if (word_ctr_q == 2'd3) begin
                    state_d = StMain;
                end
            end

            StMain: begin
                if (round_ctr_q < num_rounds) begin
                    block_d     = mix_columns(shift_rows(block_q)) ^ bus.round_key;
                    round_ctr_d = round_ctr_q + 4'd1;
                    state_d     = StSbox;
                end else begin
                    // Final round skips MixColumns; round_ctr parks at num_rounds.
                    block_d = shift_rows(block_q) ^ bus.round_key;
                    ready_d = 1'b1;
                    state_d = StIdle;
                end
            end

            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            block_q     <= '0;
            round_ctr_q <= 4'd0;
            word_ctr_q  <= 2'd0;
            keylen_q    <= 1'b0;
            ready_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            block_q     <= block_d;
            round_ctr_q <= round_ctr_d;
            word_ctr_q  <= word_ctr_d;
            keylen_q    <= keylen_d;
            ready_q     <= ready_d;
        end
    end

    assign bus.round     = round_ctr_q;
    assign bus.sboxw     = sboxw;
    assign bus.new_block = block_q;
    assign bus.ready     = ready_q;

endmodule
